// File: rtl/pipelined_adder_sub.sv
// ---------------------------------------------------------------------------
// pipelined_adder_sub
//   Parametrised, pipelined WIDTH-bit adder/subtractor. The operands are split
//   into STAGES equal segments of SEG = WIDTH/STAGES bits. Pipeline stage k
//   adds segment k and registers the segment sum together with the carry into
//   segment k+1. Below segment k the stage data holds resolved sum bits; above
//   it the data holds raw operand bits. The whole pipe advances or holds as a
//   unit, so a stalled consumer freezes every stage.
//
// Parameters
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  pipeline depth = number of carry segments (1..WIDTH)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands/mode valid this cycle
//   in_ready   out  beat accepted when in_valid && in_ready
//   a, b       in   operands (WIDTH)
//   cin        in   carry-in, add mode only
//   sub        in   1: a - b (b inverted, carry-in forced to 1)
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts when out_valid && out_ready
//   sum        out  result modulo 2^WIDTH
//   cout       out  carry out of MSB (sub: 1 = no borrow)
//   ovf        out  signed overflow
//   zero       out  result is zero (qualified by out_valid)
// ---------------------------------------------------------------------------
module pipelined_adder_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = (STAGES > 0) ? (WIDTH / STAGES) : 1;

  generate
    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % SEG) != 0) ||
        ((SEG * STAGES) != WIDTH)) begin : g_bad_params
      $error("pipelined_adder_sub: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
    end
  endgenerate

  // Pipeline advance: the only thing that can stop the pipe is a valid
  // result that the consumer refuses.
  logic adv;

  // Effective operand B and carry into segment 0.
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Stage registers.
  logic             v_q  [STAGES];
  logic [WIDTH-1:0] x_q  [STAGES];  // resolved sum bits below/at k, raw a above
  logic [WIDTH-1:0] y_q  [STAGES];  // raw b_eff bits
  logic             c_q  [STAGES];  // carry out of segment k
  logic             am_q [STAGES];  // a[MSB], kept for overflow
  logic             bm_q [STAGES];  // b_eff[MSB], kept for overflow

  // Next-state values for each stage.
  logic             v_d  [STAGES];
  logic [WIDTH-1:0] x_d  [STAGES];
  logic [WIDTH-1:0] y_d  [STAGES];
  logic             c_d  [STAGES];
  logic             am_d [STAGES];
  logic             bm_d [STAGES];

  // Per-stage sources: stage 0 reads the ports, stage k reads stage k-1.
  logic [WIDTH-1:0] sx [STAGES];
  logic [WIDTH-1:0] sy [STAGES];
  logic             sc [STAGES];

  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub ? 1'b1 : cin;
  end

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  always_comb begin
    logic [SEG:0] seg_r;
    seg_r = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sx[k]   = '0;
      sy[k]   = '0;
      sc[k]   = 1'b0;
      v_d[k]  = 1'b0;
      am_d[k] = 1'b0;
      bm_d[k] = 1'b0;
      x_d[k]  = '0;
      y_d[k]  = '0;
      c_d[k]  = 1'b0;
    end

    sx[0]   = a;
    sy[0]   = b_eff;
    sc[0]   = c0;
    v_d[0]  = in_valid;
    am_d[0] = a[WIDTH-1];
    bm_d[0] = b_eff[WIDTH-1];
    for (int unsigned k = 1; k < STAGES; k++) begin
      sx[k]   = x_q[k-1];
      sy[k]   = y_q[k-1];
      sc[k]   = c_q[k-1];
      v_d[k]  = v_q[k-1];
      am_d[k] = am_q[k-1];
      bm_d[k] = bm_q[k-1];
    end

    // Each stage resolves only its own segment; all other bits pass through.
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_r = {1'b0, sx[k][k*SEG +: SEG]} + {1'b0, sy[k][k*SEG +: SEG]}
            + {{SEG{1'b0}}, sc[k]};
      x_d[k]               = sx[k];
      x_d[k][k*SEG +: SEG] = seg_r[SEG-1:0];
      y_d[k]               = sy[k];
      c_d[k]               = seg_r[SEG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        x_q[k]  <= '0;
        y_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        am_q[k] <= 1'b0;
        bm_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]  <= v_d[k];
        x_q[k]  <= x_d[k];
        y_q[k]  <= y_d[k];
        c_q[k]  <= c_d[k];
        am_q[k] <= am_d[k];
        bm_q[k] <= bm_d[k];
      end
    end
  end

  // The final stage register is the output register.
  assign out_valid = v_q[STAGES-1];
  assign sum       = x_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = (am_q[STAGES-1] == bm_q[STAGES-1]) &&
                     (sum[WIDTH-1] != am_q[STAGES-1]);
  // Qualified by out_valid so that an empty (reset) pipe reports zero = 0.
  assign zero      = out_valid && (sum == '0);

  // Operand B has no consumer once the last segment is resolved.
  logic unused_last_y;
  assign unused_last_y = ^y_q[STAGES-1];

endmodule
